// File: rtl/spi_flash_rdid_responder.sv
// SPI mode-0 slave emulating the serial-flash RDID (0x9F) reply.
// SPI inputs are oversampled on clk; MOSI is captured on SPICLK rise and
// MISO is updated on SPICLK fall. On RDID the 24-bit ID is shifted MSB-first.
module spi_flash_rdid_responder #(
    parameter logic [7:0] RDID_OPCODE = 8'h9F,
    parameter logic [7:0] MFG_ID      = 8'h20,
    parameter logic [7:0] MEM_TYPE    = 8'h20,
    parameter logic [7:0] MEM_CAP     = 8'h15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       SPICLK,
    input  logic       SPIMOSI,
    input  logic       chip_select,
    output logic       SPIMISO,
    output logic       busy,
    output logic [7:0] opcode,
    output logic       opcode_valid,
    output logic       rdid_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RESP,
        ST_HOLD,
        ST_IGNORE
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic        r_mosi_s1, r_mosi_s2;
    logic        r_csn_s1,  r_csn_s2,  r_csn_s3;

    logic [7:0]  r_sr;
    logic [2:0]  r_bit_cnt;
    logic [23:0] r_tx;
    logic [4:0]  r_tx_cnt;
    logic        r_miso;
    logic [7:0]  r_opcode;
    logic        r_opcode_valid;
    logic        r_rdid_done;

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_csn_fall;
    logic        w_csn_rise;
    logic [7:0]  w_sr_next;
    logic        w_last_cmd_bit;
    logic        w_last_resp_bit;
    logic        w_busy;

    assign w_sclk_rise     = r_sclk_s2 & ~r_sclk_s3;
    assign w_sclk_fall     = ~r_sclk_s2 & r_sclk_s3;
    assign w_csn_fall      = ~r_csn_s2 & r_csn_s3;
    assign w_csn_rise      = r_csn_s2 & ~r_csn_s3;
    assign w_sr_next       = {r_sr[6:0], r_mosi_s2};
    assign w_last_cmd_bit  = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_last_resp_bit = w_sclk_rise && (r_tx_cnt == 5'd23);

    // Synchronisers track the pins through reset so a select held low across
    // reset does not look like a fresh falling edge afterwards.
    always_ff @(posedge clk) begin
        r_sclk_s1 <= SPICLK;
        r_sclk_s2 <= r_sclk_s1;
        r_sclk_s3 <= r_sclk_s2;
        r_mosi_s1 <= SPIMOSI;
        r_mosi_s2 <= r_mosi_s1;
        r_csn_s1  <= chip_select;
        r_csn_s2  <= r_csn_s1;
        r_csn_s3  <= r_csn_s2;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; deselect overrides any coincident SPICLK edge.
    always_comb begin
        w_state_next = r_state;
        if (w_csn_rise) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_csn_fall) begin
                        w_state_next = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (w_last_cmd_bit) begin
                        w_state_next = (w_sr_next == RDID_OPCODE) ? ST_RESP : ST_IGNORE;
                    end
                end
                ST_RESP: begin
                    if (w_last_resp_bit) begin
                        w_state_next = ST_HOLD;
                    end
                end
                ST_HOLD:   w_state_next = ST_HOLD;
                ST_IGNORE: w_state_next = ST_IGNORE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Output decode from state.
    always_comb begin
        w_busy = (r_state != ST_IDLE);
    end

    // Datapath: opcode shift, reply shift, counters, MISO and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr           <= '0;
            r_bit_cnt      <= '0;
            r_tx           <= '0;
            r_tx_cnt       <= '0;
            r_miso         <= 1'b0;
            r_opcode       <= '0;
            r_opcode_valid <= 1'b0;
            r_rdid_done    <= 1'b0;
        end else begin
            r_opcode_valid <= 1'b0;
            r_rdid_done    <= 1'b0;
            if (w_csn_rise) begin
                r_sr      <= '0;
                r_bit_cnt <= '0;
                r_tx      <= '0;
                r_tx_cnt  <= '0;
                r_miso    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_miso <= 1'b0;
                        if (w_csn_fall) begin
                            r_sr      <= '0;
                            r_bit_cnt <= '0;
                            r_tx_cnt  <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sclk_rise) begin
                            r_sr      <= w_sr_next;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_opcode       <= w_sr_next;
                                r_opcode_valid <= 1'b1;
                                if (w_sr_next == RDID_OPCODE) begin
                                    r_tx     <= {MFG_ID, MEM_TYPE, MEM_CAP};
                                    r_tx_cnt <= '0;
                                end
                            end
                        end
                    end
                    ST_RESP: begin
                        if (w_sclk_fall) begin
                            r_miso <= r_tx[23];
                            r_tx   <= {r_tx[22:0], 1'b0};
                        end
                        if (w_sclk_rise) begin
                            r_tx_cnt <= r_tx_cnt + 5'd1;
                            if (r_tx_cnt == 5'd23) begin
                                r_rdid_done <= 1'b1;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (w_sclk_fall) begin
                            r_miso <= 1'b0;
                        end
                    end
                    default: begin
                        r_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SPIMISO      = r_miso;
    assign busy         = w_busy;
    assign opcode       = r_opcode;
    assign opcode_valid = r_opcode_valid;
    assign rdid_done    = r_rdid_done;

endmodule

// File: tb/tb_spi_flash_rdid_responder.sv
// Directed bench for spi_flash_rdid_responder: a default-parameter instance
// and an instance with alternate ID bytes share the same SPI master lines.
module tb_spi_flash_rdid_responder;

    logic       clk;
    logic       reset;
    logic       SPICLK;
    logic       SPIMOSI;
    logic       chip_select;

    logic       miso1, busy1, ov1, done1;
    logic [7:0] opc1;
    logic       miso2, busy2, ov2, done2;
    logic [7:0] opc2;

    int checks   = 0;
    int failures = 0;

    int ov1_cnt   = 0;
    int done1_cnt = 0;
    int done2_cnt = 0;
    int overlap   = 0;

    spi_flash_rdid_responder dut1 (
        .clk          (clk),
        .reset        (reset),
        .SPICLK       (SPICLK),
        .SPIMOSI      (SPIMOSI),
        .chip_select  (chip_select),
        .SPIMISO      (miso1),
        .busy         (busy1),
        .opcode       (opc1),
        .opcode_valid (ov1),
        .rdid_done    (done1)
    );

    spi_flash_rdid_responder #(
        .RDID_OPCODE (8'h9F),
        .MFG_ID      (8'hEF),
        .MEM_TYPE    (8'h40),
        .MEM_CAP     (8'h18)
    ) dut2 (
        .clk          (clk),
        .reset        (reset),
        .SPICLK       (SPICLK),
        .SPIMOSI      (SPIMOSI),
        .chip_select  (chip_select),
        .SPIMISO      (miso2),
        .busy         (busy2),
        .opcode       (opc2),
        .opcode_valid (ov2),
        .rdid_done    (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for the single-cycle status outputs.
    always @(posedge clk) begin
        if (ov1)          ov1_cnt   <= ov1_cnt + 1;
        if (done1)        done1_cnt <= done1_cnt + 1;
        if (done2)        done2_cnt <= done2_cnt + 1;
        if (ov1 && done1) overlap   <= overlap + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cs_low();
        chip_select = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_high(input int half);
        repeat (half) @(negedge clk);
        chip_select = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Mode-0 master: MOSI set while SPICLK low, MISO sampled at the rising edge.
    task automatic spi_bits(input int n, input logic [31:0] tx_word, input int half,
                            output logic [31:0] rx1, output logic [31:0] rx2);
        logic [31:0] w;
        w   = tx_word;
        rx1 = '0;
        rx2 = '0;
        for (int i = 0; i < n; i++) begin
            SPIMOSI = w[n-1-i];
            repeat (half) @(negedge clk);
            rx1    = {rx1[30:0], miso1};
            rx2    = {rx2[30:0], miso2};
            SPICLK = 1'b1;
            repeat (half) @(negedge clk);
            SPICLK = 1'b0;
        end
    endtask

    logic [31:0] r1, r2;
    int ov_base, done_base, done2_base;

    initial begin
        reset       = 1'b1;
        SPICLK      = 1'b0;
        SPIMOSI     = 1'b0;
        chip_select = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_miso",   {31'd0, miso1}, 32'd0);
        check("rst_busy",   {31'd0, busy1}, 32'd0);
        check("rst_opcode", {24'd0, opc1},  32'h00);
        check("rst_ov",     {31'd0, ov1},   32'd0);
        check("rst_done",   {31'd0, done1}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 1: basic RDID
        ov_base = ov1_cnt; done_base = done1_cnt; done2_base = done2_cnt;
        cs_low();
        check("t1_busy", {31'd0, busy1}, 32'd1);
        spi_bits(8, 32'h9F, 5, r1, r2);
        check("t1_opcode", {24'd0, opc1}, 32'h9F);
        check("t1_ov_cnt", ov1_cnt - ov_base, 32'd1);
        check("t1_miso_before", r1, 32'd0);
        spi_bits(24, 32'h0, 5, r1, r2);
        check("t1_reply",      r1, 32'h202015);
        check("t1_reply_alt",  r2, 32'hEF4018);
        check("t1_done_cnt",   done1_cnt - done_base, 32'd1);
        check("t1_done2_cnt",  done2_cnt - done2_base, 32'd1);
        cs_high(5);
        check("t1_busy_end", {31'd0, busy1}, 32'd0);

        // 2: non-RDID opcode is ignored
        ov_base = ov1_cnt; done_base = done1_cnt;
        cs_low();
        spi_bits(8, 32'h03, 5, r1, r2);
        check("t2_opcode", {24'd0, opc1}, 32'h03);
        check("t2_ov_cnt", ov1_cnt - ov_base, 32'd1);
        spi_bits(16, 32'hFFFF, 5, r1, r2);
        check("t2_miso",     r1, 32'd0);
        check("t2_busy",     {31'd0, busy1}, 32'd1);
        check("t2_done_cnt", done1_cnt - done_base, 32'd0);
        cs_high(5);

        // 3: aborted reply, then a fresh full reply
        done_base = done1_cnt;
        cs_low();
        spi_bits(8, 32'h9F, 5, r1, r2);
        spi_bits(12, 32'h0, 5, r1, r2);
        check("t3_partial", r1, 32'h202);
        cs_high(5);
        check("t3_abort_done", done1_cnt - done_base, 32'd0);
        check("t3_opcode",     {24'd0, opc1}, 32'h9F);
        cs_low();
        spi_bits(8, 32'h9F, 5, r1, r2);
        spi_bits(24, 32'h0, 5, r1, r2);
        check("t3_reply",    r1, 32'h202015);
        check("t3_done_cnt", done1_cnt - done_base, 32'd1);
        cs_high(5);

        // 4: clocking past the reply yields zeros, single done pulse
        done_base = done1_cnt;
        cs_low();
        spi_bits(8, 32'h9F, 5, r1, r2);
        spi_bits(32, 32'h0, 5, r1, r2);
        check("t4_reply32",  r1, 32'h20201500);
        check("t4_done_cnt", done1_cnt - done_base, 32'd1);
        cs_high(5);

        // 5: reset mid-reply with select still low
        done_base = done1_cnt; ov_base = ov1_cnt;
        cs_low();
        spi_bits(8, 32'h9F, 5, r1, r2);
        spi_bits(5, 32'h0, 5, r1, r2);
        check("t5_partial", r1, 32'h04);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t5_miso",   {31'd0, miso1}, 32'd0);
        check("t5_busy",   {31'd0, busy1}, 32'd0);
        check("t5_opcode", {24'd0, opc1},  32'h00);
        spi_bits(8, 32'h9F, 5, r1, r2);
        spi_bits(8, 32'h0, 5, r1, r2);
        check("t5_ign_miso", r1, 32'd0);
        check("t5_ign_busy", {31'd0, busy1}, 32'd0);
        check("t5_ign_ov",   ov1_cnt - ov_base, 32'd1);
        check("t5_ign_done", done1_cnt - done_base, 32'd0);
        cs_high(5);
        cs_low();
        spi_bits(8, 32'h9F, 5, r1, r2);
        spi_bits(24, 32'h0, 5, r1, r2);
        check("t5_recover", r1, 32'h202015);
        cs_high(5);

        // 6: minimum SPICLK phases, alternate ID parameters
        done2_base = done2_cnt;
        cs_low();
        spi_bits(8, 32'h9F, 4, r1, r2);
        spi_bits(24, 32'h0, 4, r1, r2);
        check("t6_reply_alt", r2, 32'hEF4018);
        check("t6_reply_def", r1, 32'h202015);
        check("t6_opcode2",   {24'd0, opc2}, 32'h9F);
        check("t6_done2_cnt", done2_cnt - done2_base, 32'd1);
        cs_high(4);

        check("no_overlap", overlap, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
